sound_i2s_tx: RTL and testbench



---
 rtl/sound_i2s_tx_pkg.sv | 27 ++
 rtl/sound_i2s_tx_if.sv | 56 +++++
 rtl/i2s_slot_shifter.sv | 68 ++++++
 rtl/sound_i2s_tx.sv | 113 +++++++++++
 tb/tb_sound_i2s_tx.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sound_i2s_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sound_i2s_tx_pkg                                             |
// | Description : Shared audio types for the I2S transmit path: the stereo     |
// |               sample pair carried between the CDC buffer and the           |
// |               serialiser, the default slot length and the slot encoding    |
// |               of the word-select line.                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sound_i2s_tx_pkg;

  localparam int AUDIO_SAMPLE_WIDTH    = 16;
  localparam int I2S_DEFAULT_SLOT_BITS = 32;

  typedef struct packed {
    logic signed [AUDIO_SAMPLE_WIDTH-1:0] left;
    logic signed [AUDIO_SAMPLE_WIDTH-1:0] right;
  } stereo_sample_t;

  // Word-select encoding: the value is driven straight onto audio_lrck.
  typedef enum logic [0:0] {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } i2s_slot_e;

endpackage : sound_i2s_tx_pkg
`default_nettype wire

// File: rtl/sound_i2s_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sound_i2s_tx_if                                              |
// | Description : Sample-side handshake between the audio source and the I2S  |
// |               transmitter.                                                 |
// |   left_in/right_in  signed stereo sample            (source -> tx)        |
// |   sample_valid      one-cycle capture strobe         (source -> tx)        |
// |   mute              zero the slots loaded while high (source -> tx)        |
// |   volume_shift      arithmetic attenuation, only with SOUND_I2S_VOLUME_EN |
// |   sample_req        pulse at each left-slot start    (tx -> source)        |
// |   underrun/overrun  one-cycle error pulses           (tx -> source)        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface sound_i2s_tx_if #(
  parameter int SAMPLE_WIDTH = 16
);

  logic signed [SAMPLE_WIDTH-1:0] left_in;
  logic signed [SAMPLE_WIDTH-1:0] right_in;
  logic                           sample_valid;
  logic                           mute;
`ifdef SOUND_I2S_VOLUME_EN
  logic [2:0]                     volume_shift;
`endif
  logic                           sample_req;
  logic                           underrun;
  logic                           overrun;

  modport slave (
`ifdef SOUND_I2S_VOLUME_EN
    input  volume_shift,
`endif
    input  left_in,
    input  right_in,
    input  sample_valid,
    input  mute,
    output sample_req,
    output underrun,
    output overrun
  );

  modport master (
`ifdef SOUND_I2S_VOLUME_EN
    output volume_shift,
`endif
    output left_in,
    output right_in,
    output sample_valid,
    output mute,
    input  sample_req,
    input  underrun,
    input  overrun
  );

endinterface : sound_i2s_tx_if
`default_nettype wire

// File: rtl/i2s_slot_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2s_slot_shifter                                             |
// | Description : Slot timing and serial data register for the I2S            |
// |               transmitter. A free-running counter spans one slot; when it  |
// |               is zero the register loads {0, sample, zero pad} (the        |
// |               leading zero gives the I2S one-bit delay), and on every      |
// |               other bit-clock boundary it shifts left, MSB first.          |
// |   clk        audio clock                                                   |
// |   reset      synchronous, active-high                                      |
// |   load_data  sample to serialise in the next slot                          |
// |   slot_start high during the cycle whose edge begins a new slot            |
// |   dac        serial data out (register MSB)                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module i2s_slot_shifter #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_BITS    = 32,
  parameter int CLK_PER_BIT  = 4
) (
  input  wire                    clk,
  input  wire                    reset,
  input  wire [SAMPLE_WIDTH-1:0] load_data,
  output logic                   slot_start,
  output logic                   dac
);

  // The counter wraps naturally, so SLOT_BITS*CLK_PER_BIT is expected to be
  // a power of two (CLK_PER_BIT always is; SLOT_BITS is 32 in practice).
  localparam int c_cnt_w = $clog2(SLOT_BITS * CLK_PER_BIT);
  localparam int c_div_w = $clog2(CLK_PER_BIT);
  localparam int c_pad   = SLOT_BITS - SAMPLE_WIDTH - 1;

  logic [c_cnt_w-1:0]   r_count;
  logic [SLOT_BITS-1:0] r_shift;
  logic [SLOT_BITS-1:0] w_load_word;
  logic                 w_bit_en;

  // Bit boundary: low counter bits zero, excluding the slot-start edge where
  // the load takes priority.
  generate
    if (CLK_PER_BIT == 1) begin : g_div1
      assign w_bit_en = (r_count != '0);
    end else begin : g_divn
      assign w_bit_en = (r_count[c_div_w-1:0] == '0) && (r_count != '0);
    end
  endgenerate

  assign w_load_word = {{(SLOT_BITS-SAMPLE_WIDTH){1'b0}}, load_data} << c_pad;
  assign slot_start  = (r_count == '0);
  assign dac         = r_shift[SLOT_BITS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_shift <= '0;
    end else begin
      r_count <= r_count + 1'b1;
      if (slot_start) begin
        r_shift <= w_load_word;
      end else if (w_bit_en) begin
        r_shift <= {r_shift[SLOT_BITS-2:0], 1'b0};
      end
    end
  end

endmodule : i2s_slot_shifter
`default_nettype wire

// File: rtl/sound_i2s_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sound_i2s_tx                                                 |
// | Description : Stereo I2S transmitter for the Pocket audio pins. Holds one  |
// |               pending stereo pair, moves it to the active pair at each     |
// |               left-slot start, requests the next pair once per frame and   |
// |               flags underrun (no fresh pair at left start) and overrun     |
// |               (new pair overwrote an unconsumed one).                      |
// |   clk         12.288 MHz audio clock (also driven out as mclk at top)      |
// |   reset       synchronous, active-high                                     |
// |   snd         sample handshake (sound_i2s_tx_if.slave)                     |
// |   audio_lrck  word select, 0 = left, 1 = right                             |
// |   audio_dac   serial data, MSB first, one bit clock after lrck            |
// | Build option: SOUND_I2S_VOLUME_EN adds snd.volume_shift, an arithmetic    |
// |               right shift applied to each loaded slot value.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sound_i2s_tx
  import sound_i2s_tx_pkg::*;
#(
  parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
  parameter int SLOT_BITS    = I2S_DEFAULT_SLOT_BITS,
  parameter int CLK_PER_BIT  = 4
) (
  input  wire           clk,
  input  wire           reset,
  sound_i2s_tx_if.slave snd,
  output logic          audio_lrck,
  output logic          audio_dac
);

  stereo_sample_t                 r_pending;
  stereo_sample_t                 r_active;
  logic                           r_pending_fresh;
  i2s_slot_e                      r_slot;
  logic                           r_sample_req;
  logic                           r_underrun;
  logic                           r_overrun;

  stereo_sample_t                 w_next_active;
  logic                           w_slot_start;
  logic                           w_left_start;
  logic                           w_transfer;
  logic signed [SAMPLE_WIDTH-1:0] w_raw;
  logic signed [SAMPLE_WIDTH-1:0] w_data;

  always_comb begin
    // The slot about to start is the opposite of the one now on lrck.
    w_left_start  = w_slot_start && (r_slot == SLOT_RIGHT);
    w_transfer    = w_left_start && r_pending_fresh;
    // The left slot serialises the pair transferred on this very edge.
    w_next_active = w_transfer ? r_pending : r_active;
    w_raw         = w_left_start ? w_next_active.left : r_active.right;
    if (snd.mute) begin
      w_raw = '0;
    end
`ifdef SOUND_I2S_VOLUME_EN
    w_data = w_raw >>> snd.volume_shift;
`else
    w_data = w_raw;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending       <= '0;
      r_active        <= '0;
      r_pending_fresh <= 1'b0;
      r_slot          <= SLOT_RIGHT;
      r_sample_req    <= 1'b0;
      r_underrun      <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      r_sample_req <= w_left_start;
      r_underrun   <= w_left_start && !r_pending_fresh;
      // A pair consumed on this edge frees the holding register, so a
      // coincident strobe is not an overrun.
      r_overrun    <= snd.sample_valid && r_pending_fresh && !w_transfer;
      r_active     <= w_next_active;

      if (w_slot_start) begin
        r_slot <= (r_slot == SLOT_LEFT) ? SLOT_RIGHT : SLOT_LEFT;
      end

      if (snd.sample_valid) begin
        r_pending.left  <= snd.left_in;
        r_pending.right <= snd.right_in;
        r_pending_fresh <= 1'b1;
      end else if (w_transfer) begin
        r_pending_fresh <= 1'b0;
      end
    end
  end

  i2s_slot_shifter #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .SLOT_BITS    (SLOT_BITS),
    .CLK_PER_BIT  (CLK_PER_BIT)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load_data  (w_data),
    .slot_start (w_slot_start),
    .dac        (audio_dac)
  );

  assign audio_lrck     = r_slot;
  assign snd.sample_req = r_sample_req;
  assign snd.underrun   = r_underrun;
  assign snd.overrun    = r_overrun;

endmodule : sound_i2s_tx
`default_nettype wire

// File: tb/tb_sound_i2s_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sound_i2s_tx                                              |
// | Description : Directed self-checking bench for sound_i2s_tx at default     |
// |               parameters (16-bit samples, 32-bit slots, 4 clk per bit).    |
// |               k counts clock edges since reset release; slots start at     |
// |               k = 1 + 128*n, left slots at k = 1 + 256*n.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sound_i2s_tx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic audio_lrck;
  logic audio_dac;

  sound_i2s_tx_if #(.SAMPLE_WIDTH(16)) snd ();

  sound_i2s_tx dut (
    .clk        (clk),
    .reset      (reset),
    .snd        (snd),
    .audio_lrck (audio_lrck),
    .audio_dac  (audio_dac)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slot_word(input logic [15:0] d);
    return {1'b0, d, 15'b0};
  endfunction

  // Called at the negedge right after a slot-start edge; records one bit per
  // 4 cycles and flags any bit that changes within its bit period.
  // Optionally drives mute to mute_v at slot cycle mute_j.
  task automatic capture_slot(input int mute_j, input logic mute_v,
                              output logic [31:0] word, output logic stable);
    logic [31:0] w;
    logic        st;
    w  = '0;
    st = 1'b1;
    for (int j = 0; j < 128; j++) begin
      if (j == mute_j) snd.mute = mute_v;
      if ((j % 4) == 0) w[31 - j/4] = audio_dac;
      else if (w[31 - j/4] !== audio_dac) st = 1'b0;
      if (j < 127) tick();
    end
    word   = w;
    stable = st;
  endtask

  task automatic drive_pair(input logic [15:0] l, input logic [15:0] r);
    snd.left_in      = l;
    snd.right_in     = r;
    snd.sample_valid = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    logic        st;
    logic        acc;
    logic        any_u, any_o, prev_lrck;
    int          falls, bad_period, last_fall;

    snd.left_in      = '0;
    snd.right_in     = '0;
    snd.sample_valid = 1'b0;
    snd.mute         = 1'b0;
`ifdef SOUND_I2S_VOLUME_EN
    snd.volume_shift = 3'd0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_lrck",    audio_lrck,     1);
    check("rst_dac",     audio_dac,      0);
    check("rst_req",     snd.sample_req, 0);
    check("rst_underrun", snd.underrun,  0);
    check("rst_overrun", snd.overrun,    0);

    // First edge: left slot start with nothing pending
    reset = 1'b0;
    k = 0;
    tick();
    check("first_lrck",     audio_lrck,     0);
    check("first_req",      snd.sample_req, 1);
    check("first_underrun", snd.underrun,   1);
    check("first_dac",      audio_dac,      0);

    drive_pair(16'h8001, 16'h7FFE);
    tick();
    snd.sample_valid = 1'b0;
    check("cap1_overrun", snd.overrun,    0);
    check("cap1_req",     snd.sample_req, 0);
    check("cap1_underrun", snd.underrun,  0);

    acc = 1'b0;
    while (k < 128) begin
      acc |= audio_dac;
      tick();
    end
    acc |= audio_dac;
    check("first_left_zero", acc, 0);

    tick(); // 129: right slot, active pair still zero
    check("r0_lrck", audio_lrck,     1);
    check("r0_req",  snd.sample_req, 0);
    capture_slot(-1, 1'b0, w, st);
    check("r0_word",   w,  slot_word(16'h0000));
    check("r0_stable", st, 1);

    tick(); // 257: pending pair transfers
    check("l1_req",      snd.sample_req, 1);
    check("l1_underrun", snd.underrun,   0);
    check("l1_lrck",     audio_lrck,     0);
    capture_slot(-1, 1'b0, w, st);
    check("l1_word",   w,  slot_word(16'h8001));
    check("l1_stable", st, 1);
    tick(); // 385
    capture_slot(-1, 1'b0, w, st);
    check("r1_word",   w,  slot_word(16'h7FFE));
    check("r1_stable", st, 1);

    // Overrun: two pairs inside one frame
    tick(); // 513: nothing fresh
    check("l2_underrun", snd.underrun, 1);
    drive_pair(16'h1234, 16'h1111);
    tick();
    snd.sample_valid = 1'b0;
    check("ov_first", snd.overrun, 0);
    while (k < 520) tick();
    drive_pair(16'h5678, 16'h2222);
    tick();
    snd.sample_valid = 1'b0;
    check("ov_pulse", snd.overrun, 1);
    tick();
    check("ov_clear", snd.overrun, 0);
    while (k < 768) tick();
    tick(); // 769
    check("l3_req",      snd.sample_req, 1);
    check("l3_underrun", snd.underrun,   0);
    capture_slot(-1, 1'b0, w, st);
    check("l3_word", w, slot_word(16'h5678));

    drive_pair(16'h0F0F, 16'h7070);
    tick(); // 897: right slot start
    snd.sample_valid = 1'b0;
    check("refill_overrun", snd.overrun, 0);
    check("r3_lrck",        audio_lrck,  1);
    capture_slot(-1, 1'b0, w, st);
    check("r3_word", w, slot_word(16'h2222));

    // Strobe coincides with the left-start transfer
    drive_pair(16'h4444, 16'h5555);
    tick(); // 1025
    snd.sample_valid = 1'b0;
    check("coin_req",      snd.sample_req, 1);
    check("coin_underrun", snd.underrun,   0);
    check("coin_overrun",  snd.overrun,    0);
    // Mute raised mid-slot: this slot keeps its data
    capture_slot(60, 1'b1, w, st);
    check("mute_mid_word", w, slot_word(16'h0F0F));
    tick(); // 1153: muted right slot, mute released mid-slot
    capture_slot(64, 1'b0, w, st);
    check("mute_right_word", w, slot_word(16'h0000));
    tick(); // 1281
    check("l5_underrun", snd.underrun, 0);
    capture_slot(-1, 1'b0, w, st);
    check("l5_word", w, slot_word(16'h4444));

    // Steady source: answer every sample_req, 100 frames
    any_u = 1'b0;
    any_o = 1'b0;
    falls = 0;
    bad_period = 0;
    last_fall = -1;
    prev_lrck = audio_lrck;
    drive_pair(16'hFFFF, 16'h0001);
    repeat (25600) begin
      tick();
      snd.sample_valid = snd.sample_req;
      any_u |= snd.underrun;
      any_o |= snd.overrun;
      if (prev_lrck && !audio_lrck) begin
        if (last_fall >= 0 && (k - last_fall) != 256) bad_period++;
        last_fall = k;
        falls++;
      end
      prev_lrck = audio_lrck;
    end
    snd.sample_valid = 1'b0;
    check("steady_underrun", any_u,      0);
    check("steady_overrun",  any_o,      0);
    check("steady_period",   bad_period, 0);
    check("steady_frames",   falls,      100);

    // Reset with the counter at 60 inside a left slot carrying 16'hFFFF
    while (k < 27196) tick();
    check("pre_rst_lrck", audio_lrck, 0);
    check("pre_rst_dac",  audio_dac,  1);
    reset = 1'b1;
    tick();
    check("mid_rst_lrck", audio_lrck,     1);
    check("mid_rst_dac",  audio_dac,      0);
    check("mid_rst_req",  snd.sample_req, 0);
    reset = 1'b0;
    tick();
    k = 1;
    check("post_rst_lrck",     audio_lrck,     0);
    check("post_rst_req",      snd.sample_req, 1);
    check("post_rst_underrun", snd.underrun,   1);

    // Volume scaling (unscaled when the option is not built)
    drive_pair(16'h8000, 16'h0000);
`ifdef SOUND_I2S_VOLUME_EN
    snd.volume_shift = 3'd2;
`endif
    tick();
    snd.sample_valid = 1'b0;
    while (k < 256) tick();
    tick(); // 257
    check("vol_req", snd.sample_req, 1);
    capture_slot(-1, 1'b0, w, st);
`ifdef SOUND_I2S_VOLUME_EN
    check("vol_word", w, slot_word(16'hE000));
`else
    check("vol_word", w, slot_word(16'h8000));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sound_i2s_tx
`default_nettype wire
